dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder at the far end of the execute-stage memory interface.
//  Per cycle it accepts one request: word address, byte-lane store data and a 4-bit write mask.
//  It commits byte-masked stores into a word-organised synchronous RAM.
//  For loads it returns right-aligned data one cycle later. Misaligned loads arrive as two
//  back-to-back accesses; it merges their bytes into a single result. Results feed the memory/writeback stage.
// PARAMETERS
//  DEPTH_WORDS  16384  RAM size in 32-bit words (power of 2); byte address space = DEPTH_WORDS*4
//  INIT_FILE    ""     $readmemh image loaded at time 0; empty = contents X
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   asynchronous active-high reset
//  clk_en       in   1   global clock enable; 0 freezes all state, RAM and outputs
//  halt         in   1   1 freezes all state, RAM and outputs (same as clk_en=0)
//  flush        in   1   pipeline flush (exception/rfe): drop pending split, suppress response
//  addr         in   32  byte address of the access (second split half: first addr + 4)
//  store_data   in   32  store bytes already shifted to lanes; lane i = bits [8i+7:8i]
//  we           in   4   byte write mask; lane i written when we[i]=1
//  rd_en        in   1   load request this cycle
//  rd_size      in   2   0=word(32), 1=double(16), 2=byte(8); 3 treated as word
//  rd_signed    in   1   1 = sign-extend double/byte result, 0 = zero-extend
//  split_first  in   1   this load is the first half of a misaligned access
//  split_second in   1   this load is the second half (addr already advanced by 4)
//  load_data    out  32  aligned, extended load result
//  load_valid   out  1   load_data valid this cycle
//  oob          out  1   previous-cycle access was outside 0..DEPTH_WORDS*4-1
// BEHAVIOUR
//  - Accept: a request is sampled at edge k iff clk_en && !halt && !rst.
//     Registered outputs update at edge k and are stable until edge k+1 (latency 1).
//  - Index = addr[log2(DEPTH_WORDS)+1:2]; lane offset o = addr[1:0]; memory is little-endian.
//  - Store: at accepted edge, lane i of RAM[index] <= store_data lane i where we[i].
//     Nothing is written if oob or flush. Store and load are independent; a same-edge
//     read of a written word returns the OLD word. A load at k+1 sees a store from k.
//  - Reset values: load_data=0, load_valid=0, oob=0, state=IDLE, hold=0, hold_off=0, hold_size=0.
//     RAM is not reset. Reset mid-split discards the pending half with no valid pulse.
//  - FSM states IDLE, SPLIT_WAIT. Priority per accepted edge: flush > split_second > split_first > rd_en.
//    * flush: ->IDLE, load_valid<=0, no write.
//    * rd_en && !split_*: W=RAM[index]. load_data<=ext((W>>8*o) masked to size); load_valid<=1; ->IDLE.
//      Aligned/in-word cases only; an abort of SPLIT_WAIT by a plain load takes this path.
//    * split_first: hold<=RAM[index], hold_off<=o, hold_size<=rd_size; load_valid<=0; ->SPLIT_WAIT.
//      Issued while already in SPLIT_WAIT: the old hold is overwritten.
//    * split_second in SPLIT_WAIT: N=RAM[index], using the held off/size.
//      Result bytes, low to high: hold lanes hold_off..3, then N lanes 0..(need-1).
//      need = size_bytes-(4-hold_off). Extend, load_valid<=1, ->IDLE.
//      Word o=1: {N[7:0],H[31:8]}; o=2: {N[15:0],H[31:16]}; o=3: {N[23:0],H[31:24]}.
//      Double o=3: {N[7:0],H[31:24]}.
//    * split_second in IDLE: handled as a plain load of addr (no merge).
//    * no request: load_valid<=0; load_data holds its value.
//  - Extension: byte from bit 7, double from bit 15, word unchanged.
//  - oob<=1 for one cycle when an accepted load/store has addr >= DEPTH_WORDS*4.
//     That load returns 0 with load_valid=1. An oob split half forces the merged result to 0.
//  - Frozen (clk_en=0 or halt=1): no RAM write; state, hold and all outputs keep their values,
//     including load_valid.
// TESTING
//  1 Reset during SPLIT_WAIT -> load_data=0, load_valid=0, state IDLE; a following split_second merges nothing.
//  2 we=4'b1111 data 0xDEADBEEF @0x100, then rd word @0x100 -> next cycle load_data=0xDEADBEEF, valid=1.
//  3 Byte store 0x80 lane 2 (we=0100) @0x102, rd byte signed -> 0xFFFFFF80; unsigned -> 0x00000080.
//  4 RAM[0x40]=0x44332211, RAM[0x44]=0x88776655.
//    split_first word @0x41, then split_second @0x45 -> one valid pulse, load_data=0x55443322.
//  5 Same RAM; double split @0x43/@0x47 signed -> 0x00005544; flush between halves -> no valid pulse.
//  6 halt=1 with we=1111 -> RAM unchanged, outputs frozen; rd @DEPTH_WORDS*4 -> oob=1, load_data=0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM behind the execute-stage memory port.
// Stores are applied per byte lane. Loads return a right-aligned, extended result
// one cycle after the request. A misaligned load arrives as two consecutive
// accesses: the first word is parked in a hold register, and the second access
// merges it with the following word.
module dmem_responder #(
  parameter int    DEPTH_WORDS = 16384,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        halt,
  input  logic        flush,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [3:0]  we,
  input  logic        rd_en,
  input  logic [1:0]  rd_size,
  input  logic        rd_signed,
  input  logic        split_first,
  input  logic        split_second,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        oob
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [0:0] ST_IDLE       = 1'b0;
  localparam logic [0:0] ST_SPLIT_WAIT = 1'b1;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [0:0]  state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [1:0]  hold_off_q, hold_off_d;
  logic [1:0]  hold_size_q, hold_size_d;
  logic        hold_oob_q, hold_oob_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        oob_q, oob_d;

  logic          accept;
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          addr_oob;
  logic          is_load;
  logic [31:0]   rd_word;
  logic [31:0]   plain_word;
  logic [31:0]   merged_word;
  logic [5:0]    lo_shift;
  logic [5:0]    hi_shift;
  logic [3:0]    mem_we;

  assign accept   = clk_en & ~halt & ~rst;
  assign idx      = addr[AW+1:2];
  assign off      = addr[1:0];
  assign addr_oob = |addr[31:AW+2];
  assign is_load  = rd_en | split_first | split_second;

  // The word is read in the request cycle so the formatted result can be
  // registered on the accepting edge. That keeps the load latency at one cycle.
  assign rd_word    = mem_q[idx];
  assign plain_word = rd_word >> {off, 3'b000};

  // Merge: the upper (4-hold_off) bytes of the held word become the low bytes
  // of the result, and the new word fills in above them. A shift of 32 yields
  // zero, so hold_off=0 degenerates to the held word alone.
  assign lo_shift    = {1'b0, hold_off_q, 3'b000};
  assign hi_shift    = 6'd32 - lo_shift;
  assign merged_word = (hold_q >> lo_shift) | (rd_word << hi_shift);

  function automatic logic [31:0] extend(input logic [31:0] v,
                                         input logic [1:0]  sz,
                                         input logic        sgn);
    logic [31:0] r;
    case (sz)
      2'd1:    r = {{16{sgn & v[15]}}, v[15:0]};
      2'd2:    r = {{24{sgn & v[7]}},  v[7:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Next-state decode. Priority is flush, then split_second, split_first, rd_en.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_off_d   = hold_off_q;
    hold_size_d  = hold_size_q;
    hold_oob_d   = hold_oob_q;
    load_data_d  = load_data_q;
    load_valid_d = load_valid_q;
    oob_d        = oob_q;
    mem_we       = 4'b0000;
    if (accept) begin
      load_valid_d = 1'b0;
      oob_d        = 1'b0;
      if (flush) begin
        state_d = ST_IDLE;
      end else begin
        oob_d = addr_oob & (is_load | (|we));
        if (!addr_oob) begin
          mem_we = we;
        end
        if (split_second && (state_q == ST_SPLIT_WAIT)) begin
          load_data_d  = (addr_oob || hold_oob_q) ? 32'd0
                         : extend(merged_word, hold_size_q, rd_signed);
          load_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end else if (split_second || (rd_en && !split_first)) begin
          // A plain load; this also covers an orphaned second half and
          // abandons any pending first half.
          load_data_d  = addr_oob ? 32'd0 : extend(plain_word, rd_size, rd_signed);
          load_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end else if (split_first) begin
          hold_d      = addr_oob ? 32'd0 : rd_word;
          hold_oob_d  = addr_oob;
          hold_off_d  = off;
          hold_size_d = rd_size;
          state_d     = ST_SPLIT_WAIT;
        end
      end
    end
  end

  // Byte-lane RAM write. The RAM itself is never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we[i]) begin
        mem_q[idx][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
  end

  // Control state, hold register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hold_q       <= 32'd0;
      hold_off_q   <= 2'd0;
      hold_size_q  <= 2'd0;
      hold_oob_q   <= 1'b0;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
      oob_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_off_q   <= hold_off_d;
      hold_size_q  <= hold_size_d;
      hold_oob_q   <= hold_oob_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      oob_q        <= oob_d;
    end
  end

  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign oob        = oob_q;

endmodule
